// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_W,
    S_REG,
    S_DATA_W,
    S_ADDR_R,
    S_DATA_R,
    S_WAIT_IDLE,
    S_RESP
  } seq_state_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_seq_edge.sv
// Rising-edge detector for the master's level status lines (sended/received).
module i2c_seq_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Walks the byte-level I2C master through one single-byte register write or
// read (START, addr, reg, [rSTART, addr], data, STOP) and reports data/NACK.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEV_W = 7,
  parameter int REG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [DEV_W-1:0] cmd_dev,
  input  logic [REG_W-1:0] cmd_reg,
  input  logic [7:0]       cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_nack,
  output logic             m_start,
  input  logic             m_ready,
  output logic             m_send,
  output logic [7:0]       m_datasend,
  input  logic             m_sended,
  output logic             m_receive,
  input  logic [7:0]       m_datareceive,
  input  logic             m_received
);

  seq_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             rw_q, rw_d;
  logic [DEV_W-1:0] dev_q, dev_d;
  logic [REG_W-1:0] reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_nack_q, rsp_nack_d;
  logic             m_start_q, m_start_d;
  logic             m_send_q, m_send_d;
  logic             m_receive_q, m_receive_d;
  logic [7:0]       m_datasend_q, m_datasend_d;
  logic             sended_rise, received_rise;
  logic             abort;

  i2c_seq_edge u_sended_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (m_sended),
    .rise_o (sended_rise)
  );

  i2c_seq_edge u_received_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (m_received),
    .rise_o (received_rise)
  );

  // The master going idle mid-transfer (after it was seen busy) means a slave NACK.
  assign abort = busy_q & m_ready;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    rw_d         = rw_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    cmd_ready_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_nack_d   = rsp_nack_q;
    m_start_d    = 1'b0;
    m_send_d     = m_send_q;
    m_receive_d  = m_receive_q;
    m_datasend_d = m_datasend_q;

    if (state_q != S_IDLE && !m_ready) busy_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          rw_d         = cmd_rw;
          dev_d        = cmd_dev;
          reg_d        = cmd_reg;
          wdata_d      = cmd_wdata;
          m_datasend_d = {cmd_dev, 1'b0};
          m_start_d    = 1'b1;
          m_send_d     = 1'b1;
          rsp_rdata_d  = 8'h00;
          rsp_nack_d   = 1'b0;
          state_d      = S_ADDR_W;
        end else begin
          cmd_ready_d = m_ready;
        end
      end
      S_ADDR_W: begin
        if (sended_rise) begin
          m_datasend_d = reg_q;
          state_d      = S_REG;
        end
      end
      S_REG: begin
        if (sended_rise) begin
          if (rw_q == RW_WRITE) begin
            m_datasend_d = wdata_q;
            state_d      = S_DATA_W;
          end else begin
            m_send_d     = 1'b0;
            m_receive_d  = 1'b1;
            m_datasend_d = {dev_q, 1'b1};
            m_start_d    = 1'b1;
            state_d      = S_ADDR_R;
          end
        end
      end
      S_DATA_W: begin
        if (sended_rise) begin
          m_send_d = 1'b0;
          state_d  = S_WAIT_IDLE;
        end
      end
      S_ADDR_R: begin
        if (sended_rise) begin
          m_receive_d = 1'b0;
          state_d     = S_DATA_R;
        end
      end
      S_DATA_R: begin
        if (received_rise) begin
          rsp_rdata_d = m_datareceive;
          state_d     = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (m_ready) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_nack_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte edge takes priority; only once none arrived does an idle master count as NACK.
    if (abort && state_d == state_q &&
        (state_q == S_ADDR_W || state_q == S_REG || state_q == S_DATA_W ||
         state_q == S_ADDR_R || state_q == S_DATA_R)) begin
      m_send_d    = 1'b0;
      m_receive_d = 1'b0;
      rsp_nack_d  = 1'b1;
      rsp_rdata_d = 8'h00;
      rsp_valid_d = 1'b1;
      state_d     = S_RESP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      rw_q         <= RW_WRITE;
      dev_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_nack_q   <= 1'b0;
      m_start_q    <= 1'b0;
      m_send_q     <= 1'b0;
      m_receive_q  <= 1'b0;
      m_datasend_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      rw_q         <= rw_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_nack_q   <= rsp_nack_d;
      m_start_q    <= m_start_d;
      m_send_q     <= m_send_d;
      m_receive_q  <= m_receive_d;
      m_datasend_q <= m_datasend_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_nack   = rsp_nack_q;
  assign m_start    = m_start_q;
  assign m_send     = m_send_q;
  assign m_receive  = m_receive_q;
  assign m_datasend = m_datasend_q;

endmodule
